// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operand sequencer.
//
// state_e is encoded so that the state register can be driven straight onto
// the phase LED output: 00 IDLE, 01 HAVE_A, 10 ISSUE, 11 DONE.
// The OP_* constants name the 2-bit ALU op codes carried on ALUcontrol/op.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HAVE_A = 2'b01,
    ISSUE  = 2'b10,
    DONE   = 2'b11
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a falling-edge detector.
//
// Ports:
//   clk    - sampling clock
//   rst_n  - asynchronous active-low reset
//   din    - asynchronous level input (active-low key)
//   level  - synchronized copy of din
//   fall   - one-cycle pulse when the synchronized level goes 1 -> 0
//
// The synchronizer flops reset to RstVal (released). The edge detector stays
// disarmed until the synchronizer has been refilled with real samples, so a
// key already held down across reset release does not produce a pulse; a
// genuine release must be seen before the next press is reported.
module sync_edge #(
  parameter logic RstVal = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic fall
);

  logic       meta_q;
  logic       sync_q;
  logic       prev_q;
  logic [1:0] fill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RstVal;
      sync_q <= RstVal;
      prev_q <= 1'b0;
      fill_q <= 2'b00;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      fill_q <= {fill_q[0], 1'b1};
      // Until fill_q[1] is set, sync_q still holds the reset value.
      prev_q <= fill_q[1] ? sync_q : 1'b0;
    end
  end

  assign level = sync_q;
  assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Entry stage for the 8-bit ALU datapath.
//
// Turns presses of the shared entry key into one complete operation
// (operand A + op code, then operand B) and offers it downstream with a
// valid/ready handshake. A cancel key, an abandon timeout while waiting for
// operand B, and a phase indicator for LEDs are provided.
//
// Ports:
//   CLK50M       - 50 MHz system clock
//   RSTb         - asynchronous active-low reset
//   KEYb         - debounced entry key, active-low, asynchronous
//   CANCELb      - debounced cancel key, active-low level, asynchronous
//   INPUT        - shared operand switches
//   ALUcontrol   - op switches (ADD/SUB/AND/OR)
//   ready        - downstream accepts when high together with valid
//   A, B, op     - captured operation
//   valid        - operation offered downstream (registered)
//   phase        - 00 IDLE, 01 HAVE_A, 10 ISSUE, 11 DONE
//   timeout_flag - sticky: last entry was abandoned by timeout
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned N              = 8,
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input  logic         CLK50M,
  input  logic         RSTb,
  input  logic         KEYb,
  input  logic         CANCELb,
  input  logic [N-1:0] INPUT,
  input  logic [1:0]   ALUcontrol,
  input  logic         ready,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic [1:0]   op,
  output logic         valid,
  output logic [1:0]   phase,
  output logic         timeout_flag
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  // Key conditioning
  logic key_level_unused;
  logic press_evt;
  logic cancel_sync;
  logic cancel_fall_unused;
  logic cancel_lvl;

  sync_edge #(
    .RstVal(1'b1)
  ) u_key_sync (
    .clk  (CLK50M),
    .rst_n(RSTb),
    .din  (KEYb),
    .level(key_level_unused),
    .fall (press_evt)
  );

  sync_edge #(
    .RstVal(1'b1)
  ) u_cancel_sync (
    .clk  (CLK50M),
    .rst_n(RSTb),
    .din  (CANCELb),
    .level(cancel_sync),
    .fall (cancel_fall_unused)
  );

  assign cancel_lvl = ~cancel_sync;

  // State
  state_e          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [1:0]      op_q, op_d;
  logic            valid_q, valid_d;
  logic            tflag_q, tflag_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK50M or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      valid_q <= 1'b0;
      tflag_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
      tflag_q <= tflag_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    tflag_d = tflag_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (press_evt) begin
          a_d     = INPUT;
          op_d    = ALUcontrol;
          tflag_d = 1'b0;
          cnt_d   = '0;
          state_d = HAVE_A;
        end
      end

      HAVE_A: begin
        // Priority: cancel > press > timeout.
        if (cancel_lvl) begin
          state_d = IDLE;
        end else if (press_evt) begin
          b_d     = INPUT;
          state_d = ISSUE;
        end else if (cnt_q == CntLast) begin
          tflag_d = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ISSUE: begin
        // Key and cancel are dropped here: an offered operation is never withdrawn.
        if (ready) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (cancel_lvl) begin
          state_d = IDLE;
        end else if (press_evt) begin
          a_d     = INPUT;
          op_d    = ALUcontrol;
          tflag_d = 1'b0;
          cnt_d   = '0;
          state_d = HAVE_A;
        end
      end

      default: state_d = IDLE;
    endcase

    // valid is registered from the next state, so ready never reaches it combinationally.
    valid_d = (state_d == ISSUE);
  end

  assign A            = a_q;
  assign B            = b_q;
  assign op           = op_q;
  assign valid        = valid_q;
  assign phase        = state_q;
  assign timeout_flag = tflag_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       key_n    = 1'b1;
  logic       cancel_n = 1'b1;
  logic       ready    = 1'b0;
  logic [7:0] in_sw    = 8'h00;
  logic [1:0] alu_ctl  = 2'b00;

  logic [7:0] a_out;
  logic [7:0] b_out;
  logic [1:0] op_out;
  logic       valid;
  logic [1:0] phase;
  logic       timeout_flag;

  int checks      = 0;
  int errors      = 0;
  int valid_total = 0;

  alu_operand_sequencer #(
    .N             (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK50M      (clk),
    .RSTb        (rst_n),
    .KEYb        (key_n),
    .CANCELb     (cancel_n),
    .INPUT       (in_sw),
    .ALUcontrol  (alu_ctl),
    .ready       (ready),
    .A           (a_out),
    .B           (b_out),
    .op          (op_out),
    .valid       (valid),
    .phase       (phase),
    .timeout_flag(timeout_flag)
  );

  always #10 clk = ~clk;

  // Number of cycles valid was high, sampled mid-cycle.
  always @(negedge clk) if (valid === 1'b1) valid_total++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic press_key(input logic [7:0] sw);
    in_sw = sw;
    @(negedge clk) key_n = 1'b0;
    repeat (4) @(negedge clk);
    key_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    key_n = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (phase !== 2'b00) begin errors++;
      $display("FAIL reset_phase: got %b expected 00", phase); end
    checks++; if (a_out !== 8'h00 || b_out !== 8'h00) begin errors++;
      $display("FAIL reset_ab: got A=%h B=%h expected 00/00", a_out, b_out); end
    checks++; if (op_out !== 2'b00 || valid !== 1'b0 || timeout_flag !== 1'b0) begin errors++;
      $display("FAIL reset_ctl: got op=%b valid=%b tf=%b expected 00/0/0",
               op_out, valid, timeout_flag); end
    key_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_normal_entry;
    int v0;
    ready   = 1'b1;
    alu_ctl = 2'b01;
    press_key(8'h35);
    checks++; if (phase !== 2'b01) begin errors++;
      $display("FAIL entry_phase_a: got %b expected 01", phase); end
    checks++; if (a_out !== 8'h35 || op_out !== 2'b01) begin errors++;
      $display("FAIL entry_capture_a: got A=%h op=%b expected 35/01", a_out, op_out); end
    alu_ctl = 2'b10;
    v0 = valid_total;
    press_key(8'h0C);
    checks++; if (valid_total - v0 != 1) begin errors++;
      $display("FAIL entry_valid_len: got %0d cycles expected 1", valid_total - v0); end
    checks++; if (phase !== 2'b11 || valid !== 1'b0) begin errors++;
      $display("FAIL entry_done: got phase=%b valid=%b expected 11/0", phase, valid); end
    checks++; if (a_out !== 8'h35 || b_out !== 8'h0C || op_out !== 2'b01) begin errors++;
      $display("FAIL entry_operands: got A=%h B=%h op=%b expected 35/0c/01",
               a_out, b_out, op_out); end
  endtask

  task automatic test_backpressure;
    int   v0;
    int   stable_err;
    logic found;
    ready   = 1'b0;
    alu_ctl = 2'b11;
    press_key(8'h7F);
    checks++; if (phase !== 2'b01 || a_out !== 8'h7F || op_out !== 2'b11) begin errors++;
      $display("FAIL bp_capture_a: got phase=%b A=%h op=%b expected 01/7f/11",
               phase, a_out, op_out); end
    in_sw   = 8'h81;
    alu_ctl = 2'b00;
    v0      = valid_total;
    found   = 1'b0;
    @(negedge clk) key_n = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (phase === 2'b10) found = 1'b1;
    end
    checks++; if (!found) begin errors++;
      $display("FAIL bp_enter_issue: got phase=%b expected 10 within 10 cycles", phase); end
    // Cycle 1 of ISSUE observed; ready stays low through cycle 20.
    stable_err = 0;
    for (int i = 2; i <= 21; i++) begin
      @(negedge clk);
      if (a_out !== 8'h7F || b_out !== 8'h81 || op_out !== 2'b11 || valid !== 1'b1)
        stable_err++;
      if (i == 3) key_n = 1'b1;
      if (i == 8) begin in_sw = 8'h55; key_n = 1'b0; end
      if (i == 14) key_n = 1'b1;
      if (i == 21) ready = 1'b1;
    end
    @(negedge clk);
    checks++; if (stable_err != 0) begin errors++;
      $display("FAIL bp_stable: got %0d unstable cycles expected 0", stable_err); end
    checks++; if (valid_total - v0 != 21) begin errors++;
      $display("FAIL bp_valid_len: got %0d cycles expected 21", valid_total - v0); end
    checks++; if (phase !== 2'b11 || valid !== 1'b0) begin errors++;
      $display("FAIL bp_done: got phase=%b valid=%b expected 11/0", phase, valid); end
    repeat (5) @(negedge clk);
    checks++; if (phase !== 2'b11 || b_out !== 8'h81 || a_out !== 8'h7F) begin errors++;
      $display("FAIL bp_press_dropped: got phase=%b A=%h B=%h expected 11/7f/81",
               phase, a_out, b_out); end
  endtask

  task automatic test_timeout;
    int   n;
    logic found;
    logic left;
    alu_ctl = 2'b00;
    in_sw   = 8'hA0;
    found   = 1'b0;
    @(negedge clk) key_n = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (phase === 2'b01) found = 1'b1;
    end
    checks++; if (!found) begin errors++;
      $display("FAIL to_enter_have_a: got phase=%b expected 01", phase); end
    n    = 1;
    left = 1'b0;
    for (int i = 0; i < 40 && !left; i++) begin
      @(negedge clk);
      if (i == 2) key_n = 1'b1;
      if (phase === 2'b01) n++;
      else left = 1'b1;
    end
    checks++; if (n != 16) begin errors++;
      $display("FAIL to_length: got %0d cycles in HAVE_A expected 16", n); end
    checks++; if (phase !== 2'b00 || timeout_flag !== 1'b1 || a_out !== 8'hA0) begin errors++;
      $display("FAIL to_abandon: got phase=%b tf=%b A=%h expected 00/1/a0",
               phase, timeout_flag, a_out); end
    repeat (3) @(negedge clk);
    press_key(8'h3C);
    checks++; if (phase !== 2'b01 || timeout_flag !== 1'b0 || a_out !== 8'h3C) begin errors++;
      $display("FAIL to_rearm: got phase=%b tf=%b A=%h expected 01/0/3c",
               phase, timeout_flag, a_out); end
  endtask

  task automatic test_cancel;
    int v0;
    v0 = valid_total;
    in_sw = 8'h99;
    @(negedge clk);
    key_n    = 1'b0;
    cancel_n = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (phase !== 2'b00) begin errors++;
      $display("FAIL cancel_phase: got %b expected 00", phase); end
    checks++; if (b_out !== 8'h81 || a_out !== 8'h3C) begin errors++;
      $display("FAIL cancel_retain: got A=%h B=%h expected 3c/81", a_out, b_out); end
    checks++; if (valid_total != v0) begin errors++;
      $display("FAIL cancel_no_valid: got %0d valid cycles expected 0", valid_total - v0); end
    key_n    = 1'b1;
    cancel_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_issue;
    ready   = 1'b0;
    alu_ctl = 2'b10;
    press_key(8'h11);
    press_key(8'h22);
    checks++; if (phase !== 2'b10 || valid !== 1'b1 || op_out !== 2'b10) begin errors++;
      $display("FAIL rst_mid_setup: got phase=%b valid=%b op=%b expected 10/1/10",
               phase, valid, op_out); end
    @(negedge clk);
    #3 rst_n = 1'b0;
    #2;
    checks++; if (valid !== 1'b0 || phase !== 2'b00) begin errors++;
      $display("FAIL rst_mid_async: got valid=%b phase=%b expected 0/00", valid, phase); end
    checks++; if (a_out !== 8'h00 || b_out !== 8'h00 || op_out !== 2'b00) begin errors++;
      $display("FAIL rst_mid_regs: got A=%h B=%h op=%b expected 00/00/00",
               a_out, b_out, op_out); end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_normal_entry();
    test_backpressure();
    test_timeout();
    test_cancel();
    test_reset_mid_issue();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
